// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 in-place DIT FFT datapath: sequencer states,
// width helpers derived from the FFT length and the twiddle generator latency.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } fsm_state_t;

  // Twiddle generator latency; the sequencer delays its sideband by this much.
  localparam int TW_LAT_DEFAULT = 2;

  function automatic int stages_of(input int n);
    return $clog2(n);
  endfunction

  function automatic int aw_of(input int n);
    return $clog2(n);
  endfunction

  function automatic int kw_of(input int n);
    return $clog2(n / 2);
  endfunction

  function automatic int sw_of(input int n);
    return $clog2($clog2(n));
  endfunction

endpackage

// File: rtl/tw_delay_line.sv
// Free-running WIDTH x DEPTH shift register with asynchronous reset, used to
// align sideband data with fixed-latency datapath blocks. DEPTH must be >= 1.
module tw_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the pipe to one stage.
  // NOTE: every stage is reset, not just the tail: a stale valid bit left in the
  // pipe would otherwise emerge as a spurious butterfly after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_addr_gen.sv
// Per-frame address/twiddle sequencer for a shared-butterfly radix-2 in-place DIT FFT.
// Issues (k, stage) immediately and (addr_a, addr_b, valid) TW_LAT cycles later.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter  int N         = 8192,
  parameter  int TW_LAT    = TW_LAT_DEFAULT,
  parameter  int STAGE_GAP = 4,
  localparam int STAGES    = stages_of(N),
  localparam int AW        = aw_of(N),
  localparam int KW        = kw_of(N),
  localparam int SW        = sw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bf_ready,
  output logic [KW-1:0] k,
  output logic [SW-1:0] stage,
  output logic          iss_valid,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic          bf_valid,
  output logic          bf_last,
  output logic          busy,
  output logic          done
);

  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [KW-1:0] J_LAST = KW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STAGES - 1);
  localparam logic [GW-1:0] G_LAST = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  typedef struct packed {
    logic          valid;
    logic          last;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } side_t;

  fsm_state_t    state_q, state_d;
  logic [KW-1:0] j_q, j_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [AW-1:0] j_ext, half, mask, pos, a_cur, b_cur;
  logic [SW-1:0] k_shift;
  logic [AW-1:0] hold_a, hold_b;
  side_t         side_in, side_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      stage_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is assigned a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    j_d       = j_q;
    stage_d   = stage_q;
    gap_d     = gap_q;
    iss_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          j_d     = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        iss_valid = bf_ready;
        if (bf_ready) begin
          if (j_q == J_LAST) begin
            j_d = '0;
            if (stage_q == S_LAST) begin
              state_d = DRAIN;
              stage_d = '0;
            end else begin
              stage_d = stage_q + 1'b1;
              gap_d   = '0;
              if (STAGE_GAP > 0) state_d = GAP;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == G_LAST) state_d = RUN;
        else                 gap_d   = gap_q + 1'b1;
      end
      DRAIN: begin
        if (side_out.valid && side_out.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // a inserts a zero bit at position 'stage' into j; b sets that bit.
  assign j_ext   = AW'(j_q);
  assign half    = AW'(1) << stage_q;
  assign mask    = half - 1'b1;
  assign pos     = j_ext & mask;
  assign a_cur   = ((j_ext & ~mask) << 1) | pos;
  assign b_cur   = a_cur | half;
  assign k_shift = S_LAST - stage_q;
  assign k       = KW'(pos << k_shift);
  assign stage   = stage_q;

  assign side_in = '{
    valid: iss_valid,
    last:  iss_valid && (j_q == J_LAST) && (stage_q == S_LAST),
    a:     a_cur,
    b:     b_cur
  };

  tw_delay_line #(
    .WIDTH($bits(side_t)),
    .DEPTH(TW_LAT)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .din (side_in),
    .dout(side_out)
  );

  // Addresses seen by the butterfly freeze on the last valid pair between bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_a <= '0;
      hold_b <= '0;
    end else if (side_out.valid) begin
      hold_a <= side_out.a;
      hold_b <= side_out.b;
    end
  end

  assign addr_a   = side_out.valid ? side_out.a : hold_a;
  assign addr_b   = side_out.valid ? side_out.b : hold_b;
  assign bf_valid = side_out.valid;
  assign bf_last  = side_out.valid & side_out.last;
  assign done     = bf_last;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen at N=8, TW_LAT=2: one instance with STAGE_GAP=0, one with 3.
module tb_fft_addr_gen;

  localparam int NN  = 8;
  localparam int STG = 3;
  localparam int TWL = 2;
  localparam int NBF = STG * NN / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i   [2];
  logic start_i [2];
  logic rdy_i   [2];

  logic [1:0] k0, k1, st0, st1;
  logic [2:0] a0, a1, b0, b1;
  logic iv0, iv1, bv0, bv1, bl0, bl1, busy0, busy1, done0, done1;

  fft_addr_gen #(.N(NN), .TW_LAT(TWL), .STAGE_GAP(0)) dut0 (
    .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .bf_ready(rdy_i[0]),
    .k(k0), .stage(st0), .iss_valid(iv0), .addr_a(a0), .addr_b(b0),
    .bf_valid(bv0), .bf_last(bl0), .busy(busy0), .done(done0)
  );

  fft_addr_gen #(.N(NN), .TW_LAT(TWL), .STAGE_GAP(3)) dut1 (
    .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .bf_ready(rdy_i[1]),
    .k(k1), .stage(st1), .iss_valid(iv1), .addr_a(a1), .addr_b(b1),
    .bf_valid(bv1), .bf_last(bl1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [31:0] k, stg, iv, a, b, bv, bl, busy, done;
  } obs_t;

  typedef struct {
    bit ready;
    bit iss;
    bit ks_care;
    int k;
    int stg;
    bit bfv;
    int a;
    int b;
    bit last;
    bit done;
  } row_t;

  int n_checks = 0;
  int n_err    = 0;
  int exp_a [NBF];
  int exp_b [NBF];
  int exp_k [NBF];
  int exp_s [NBF];
  row_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic obs_t get_obs(input int u);
    obs_t o;
    if (u == 0) begin
      o.k = 32'(k0); o.stg = 32'(st0); o.iv = 32'(iv0); o.a = 32'(a0); o.b = 32'(b0);
      o.bv = 32'(bv0); o.bl = 32'(bl0); o.busy = 32'(busy0); o.done = 32'(done0);
    end else begin
      o.k = 32'(k1); o.stg = 32'(st1); o.iv = 32'(iv1); o.a = 32'(a1); o.b = 32'(b1);
      o.bv = 32'(bv1); o.bl = 32'(bl1); o.busy = 32'(busy1); o.done = 32'(done1);
    end
    return o;
  endfunction

  task automatic check_zero(input int u, input string name);
    obs_t o;
    o = get_obs(u);
    check(name, o.k | o.stg | o.iv | o.a | o.b | o.bv | o.bl | o.busy | o.done, 0);
  endtask

  // Reference butterfly order: stages outermost, butterfly index innermost.
  function automatic void build_model();
    int idx = 0;
    for (int s = 0; s < STG; s++) begin
      for (int j = 0; j < NN / 2; j++) begin
        int half = 1 << s;
        int pos  = j % half;
        exp_a[idx] = (j / half) * 2 * half + pos;
        exp_b[idx] = exp_a[idx] + half;
        exp_k[idx] = pos * ((NN / 2) / half);
        exp_s[idx] = s;
        idx++;
      end
    end
  endfunction

  task automatic fill_table();
    tbl[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 0, 1, 0, 1, 0, 0};
    tbl[3]  = '{1, 1, 1, 0, 0, 1, 2, 3, 0, 0};
    tbl[4]  = '{1, 1, 1, 0, 1, 1, 4, 5, 0, 0};
    tbl[5]  = '{1, 1, 1, 2, 1, 1, 6, 7, 0, 0};
    tbl[6]  = '{1, 1, 1, 0, 1, 1, 0, 2, 0, 0};
    tbl[7]  = '{1, 1, 1, 2, 1, 1, 1, 3, 0, 0};
    tbl[8]  = '{1, 1, 1, 0, 2, 1, 4, 6, 0, 0};
    tbl[9]  = '{1, 1, 1, 1, 2, 1, 5, 7, 0, 0};
    tbl[10] = '{1, 1, 1, 2, 2, 1, 0, 4, 0, 0};
    tbl[11] = '{1, 1, 1, 3, 2, 1, 1, 5, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 2, 6, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 1, 3, 7, 1, 1};
  endtask

  task automatic run_table();
    obs_t o;
    start_i[0] = 1'b1;
    rdy_i[0]   = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      rdy_i[0] = tbl[i].ready;
      @(negedge clk);
      o = get_obs(0);
      check($sformatf("tbl%0d_iss", i), o.iv, 32'(tbl[i].iss));
      if (tbl[i].ks_care) begin
        check($sformatf("tbl%0d_k", i), o.k, tbl[i].k);
        check($sformatf("tbl%0d_stage", i), o.stg, tbl[i].stg);
      end
      check($sformatf("tbl%0d_bfv", i), o.bv, 32'(tbl[i].bfv));
      check($sformatf("tbl%0d_a", i), o.a, tbl[i].a);
      check($sformatf("tbl%0d_b", i), o.b, tbl[i].b);
      check($sformatf("tbl%0d_last", i), o.bl, 32'(tbl[i].last));
      check($sformatf("tbl%0d_done", i), o.done, 32'(tbl[i].done));
      check($sformatf("tbl%0d_busy", i), o.busy, 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    o = get_obs(0);
    check("tbl_busy_after_done", o.busy, 0);
  endtask

  // mode 0: ready tied high; 1: stall once at issue stall_at; 2: random ready.
  task automatic run_frame(input int u, input int mode, input int stall_at,
                           input int stall_len, input bit poke);
    obs_t o;
    int iss_n = 0, bf_n = 0, stalled = 0, c = 0;
    int gap = (u == 0) ? 0 : 3;
    int iss_cyc [$];
    bit fin = 0;
    bit r;
    start_i[u] = 1'b1;
    rdy_i[u]   = 1'b1;
    @(posedge clk); #1;
    start_i[u] = 1'b0;
    while (!fin && c < 400) begin
      c++;
      if (c > 1) begin @(posedge clk); #1; end
      case (mode)
        1:       r = !(iss_n == stall_at && stalled < stall_len);
        2:       r = ($urandom_range(0, 3) != 0);
        default: r = 1'b1;
      endcase
      if (mode == 1 && !r) stalled++;
      rdy_i[u]   = r;
      start_i[u] = poke && (c == 5 || c == 9);
      @(negedge clk);
      o = get_obs(u);
      check("busy", o.busy, 1);
      if (!r) check("iss_while_stalled", o.iv, 0);
      if (iss_n < NBF) begin
        check($sformatf("k_%0d", iss_n), o.k, exp_k[iss_n]);
        check($sformatf("stage_%0d", iss_n), o.stg, exp_s[iss_n]);
      end
      if (o.iv == 1) begin
        if (iss_n >= NBF) check("extra_issue", 1, 0);
        iss_cyc.push_back(c);
        iss_n++;
      end
      if (o.bv == 1) begin
        if (bf_n < NBF) begin
          check($sformatf("addr_a_%0d", bf_n), o.a, exp_a[bf_n]);
          check($sformatf("addr_b_%0d", bf_n), o.b, exp_b[bf_n]);
          check($sformatf("bf_align_%0d", bf_n), c,
                (bf_n < iss_cyc.size()) ? iss_cyc[bf_n] + TWL : -1);
          check($sformatf("bf_last_%0d", bf_n), o.bl, 32'(bf_n == NBF - 1));
          check($sformatf("done_%0d", bf_n), o.done, 32'(bf_n == NBF - 1));
        end else begin
          check("extra_bf_valid", 1, 0);
        end
        bf_n++;
        if (bf_n >= NBF) fin = 1;
      end else begin
        check("bf_last_idle", o.bl, 0);
        check("done_idle", o.done, 0);
        if (bf_n > 0) begin
          check("addr_a_hold", o.a, exp_a[bf_n-1]);
          check("addr_b_hold", o.b, exp_b[bf_n-1]);
        end
      end
    end
    if (!fin) check("frame_timeout", 0, 1);
    start_i[u] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    o = get_obs(u);
    check("busy_after_done", o.busy, 0);
    check("done_after_done", o.done, 0);
    check("issue_count", iss_n, NBF);
    check("bf_count", bf_n, NBF);
    if (mode == 0 && iss_cyc.size() == NBF) begin
      check("last_issue_cycle", iss_cyc[NBF-1], NBF + (STG - 1) * gap);
      check("gap_stage0_1", iss_cyc[4] - iss_cyc[3] - 1, gap);
      check("gap_stage1_2", iss_cyc[8] - iss_cyc[7] - 1, gap);
    end
  endtask

  task automatic reset_with_start();
    obs_t o;
    rst_i[0] = 1'b1; rst_i[1] = 1'b1;
    start_i[0] = 1'b1; start_i[1] = 1'b0;
    rdy_i[0] = 1'b0; rdy_i[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero(0, "reset_start_held_u0");
      check_zero(1, "reset_idle_u1");
    end
    @(posedge clk); #1;
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;
    @(negedge clk);
    o = get_obs(0);
    check("busy_at_release", o.busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    o = get_obs(0);
    check("busy_cycle_after_release", o.busy, 1);
    rst_i[0] = 1'b1;
    start_i[0] = 1'b0;
    @(posedge clk); #1;
    rst_i[0] = 1'b0;
    @(negedge clk);
    check_zero(0, "idle_after_rereset");
  endtask

  task automatic reset_mid_frame();
    obs_t o;
    int n = 0;
    start_i[0] = 1'b1;
    rdy_i[0]   = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    for (int c = 0; c < 50 && n < 6; c++) begin
      @(negedge clk);
      o = get_obs(0);
      if (o.iv == 1) n++;
    end
    check("issues_before_reset", n, 6);
    @(posedge clk); #1;
    rst_i[0] = 1'b1;
    #1;
    check_zero(0, "async_reset_mid_frame");
    repeat (4) begin
      @(negedge clk);
      check_zero(0, "reset_hold_no_done");
    end
    @(posedge clk); #1;
    rst_i[0] = 1'b0;
    @(negedge clk);
    check_zero(0, "idle_after_mid_reset");
    run_frame(0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    build_model();
    fill_table();
    reset_with_start();
    run_table();
    run_frame(1, 0, 0, 0, 1'b0);
    run_frame(0, 1, 6, 5, 1'b0);
    run_frame(1, 1, 6, 5, 1'b0);
    run_frame(0, 0, 0, 0, 1'b1);
    reset_mid_frame();
    for (int i = 0; i < 6; i++) run_frame(i % 2, 2, 0, 0, (i % 3) == 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
